// File: rtl/iir_ram_pkg.sv
// Shared constants and types for the IIR coefficient/state RAM arbiter.
// RAM geometry is fixed by the 1024x32 single-port macro.
package iir_ram_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_HOST,
        OWN_ENG
    } owner_t;

endpackage

// File: rtl/iir_ram_starve_ctr.sv
// Saturating count of consecutive cycles the host has lost arbitration.
// max_o flags that the host must be given the next unlocked slot.
module iir_ram_starve_ctr #(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic max_o
);

    localparam logic [CNT_W-1:0] MaxVal = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;

    assign max_o = (cnt_q == MaxVal);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !max_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/iir_ram_arbiter.sv
// Shares the IIR filter's single-port coefficient/state RAM between the host
// Avalon-MM slave and the filter engine; engine has priority, host is starvation-protected.
module iir_ram_arbiter
    import iir_ram_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    // Host Avalon-MM slave
    input  logic [ADDR_W-1:0] h_address,
    input  logic              h_read,
    input  logic              h_write,
    input  logic [DATA_W-1:0] h_writedata,
    input  logic [BE_W-1:0]   h_byteenable,
    output logic              h_waitrequest,
    output logic [DATA_W-1:0] h_readdata,
    output logic              h_readdatavalid,
    // Filter engine
    input  logic              e_req,
    input  logic              e_we,
    input  logic              e_lock,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic [DATA_W-1:0] e_rdata,
    output logic              e_rvalid,
    // RAM port
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_write,
    output logic              ram_chipselect,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic   host_req;
    logic   engine_win;
    logic   host_win;
    logic   starve_max;
    logic   lock_held;
    owner_t rd_owner;

    assign host_req = h_read | h_write;

    // A held lock overrides starvation so an engine burst is never split.
    assign engine_win = reset_n & e_req & (lock_held | ~starve_max);
    assign host_win   = reset_n & host_req & ~engine_win;

    iir_ram_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .clr_i  (~host_req | host_win),
        .inc_i  (host_req & ~host_win),
        .max_o  (starve_max)
    );

    always_comb begin
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        ram_write      = 1'b0;
        ram_chipselect = 1'b0;
        ram_clken      = 1'b0;
        if (engine_win) begin
            ram_address    = e_addr;
            ram_byteenable = '1;
            ram_writedata  = e_wdata;
            ram_write      = e_we;
            ram_chipselect = 1'b1;
            ram_clken      = 1'b1;
        end else if (host_win) begin
            ram_address    = h_address;
            ram_byteenable = h_byteenable;
            ram_writedata  = h_writedata;
            ram_write      = h_write;
            ram_chipselect = 1'b1;
            ram_clken      = 1'b1;
        end
    end

    assign h_waitrequest   = ~reset_n | (host_req & ~host_win);
    assign e_gnt           = engine_win;
    assign h_readdatavalid = reset_n & (rd_owner == OWN_HOST);
    assign e_rvalid        = reset_n & (rd_owner == OWN_ENG);
    assign h_readdata      = reset_n ? ram_readdata : '0;
    assign e_rdata         = reset_n ? ram_readdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_held <= 1'b0;
            rd_owner  <= OWN_NONE;
        end else begin
            lock_held <= engine_win & e_lock;
            if (engine_win && !e_we) begin
                rd_owner <= OWN_ENG;
            end else if (host_win && h_read) begin
                rd_owner <= OWN_HOST;
            end else begin
                rd_owner <= OWN_NONE;
            end
        end
    end

endmodule

// File: doc/iir_ram_arbiter.md
# iir_ram_arbiter

Two-requester access controller for the IIR filter's 1024×32 single-port coefficient/state RAM. It shares the RAM's single port between the host Avalon-MM slave (coefficient load/readback) and the filter engine (per-sample coefficient and state fetch/update). It issues at most one RAM access per cycle and returns 1-cycle read data to the owner. Engine traffic has priority, and a starvation counter guarantees the host progress.

## Interface
- ADDR_W, 10, RAM word-address width
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- STARVE_MAX, 8, consecutive lost host cycles before the host is forced a slot (1..255)
- clk  in  1  single clock
- reset_n  in  1  reset, asynchronous, active-low
- h_address  in  ADDR_W  host word address
- h_read / h_write  in  1  host read / write request (never both)
- h_writedata  in  DATA_W  host write data
- h_byteenable  in  BE_W  host byte enables
- h_waitrequest  out  1  host stall; 1 = request not accepted this cycle
- h_readdata  out  DATA_W  host read data
- h_readdatavalid  out  1  host read data valid
- e_req  in  1  engine access request
- e_we  in  1  engine write (1) / read (0)
- e_lock  in  1  engine holds the port for its next beat (biquad burst)
- e_addr  in  ADDR_W  engine address
- e_wdata  in  DATA_W  engine write data (all bytes written)
- e_gnt  out  1  engine access accepted this cycle
- e_rdata  out  DATA_W  engine read data
- e_rvalid  out  1  engine read data valid
- ram_address, ram_byteenable, ram_writedata, ram_write, ram_chipselect, ram_clken  out  to RAM
- ram_readdata  in  DATA_W  RAM q (input-registered, output unregistered)

## Operation
- Per-cycle winner is combinational from the requests and registered state `{lock_held, starve_cnt}`.
  - Engine wins if e_req and (lock_held or starve_cnt < STARVE_MAX).
  - Otherwise the host wins if it has a request.
  - Otherwise there is no access.
- Winner drives the RAM:
  - ram_chipselect = ram_clken = 1; ram_write = request write bit.
  - Engine: byteenable = all ones.
  - Idle: chipselect = write = clken = 0; address/data hold 0.
- h_waitrequest = (h_read | h_write) & ~host_win; e_gnt = engine_win.
- lock_held <= engine_win & e_lock. It holds the grant next cycle even if the host is starved; the counter saturates meanwhile.
- starve_cnt:
  - Cleared when the host wins or has no request.
  - Incremented (saturating at STARVE_MAX) when the host requests and loses.
- rd_owner register {NONE, HOST, ENG} <= owner of a granted read, else NONE.
- Next cycle: h_readdatavalid = (rd_owner == HOST), e_rvalid = (rd_owner == ENG). Both data outputs pass ram_readdata through.
- Writes complete at the grant edge. There is no response for writes.
- Reset (async):
  - rd_owner = NONE, starve_cnt = 0, lock_held = 0.
  - While reset_n = 0: all RAM outputs 0, e_gnt = 0, valids 0, h_waitrequest = 1, data outputs 0.
  - A read in flight at reset is discarded; no valid is issued after release.

## Timing
- Grant: same cycle as request (0 wait) when uncontested.
- Read latency: data and valid exactly 1 cycle after the granted cycle.
- Throughput: 1 access/cycle, with back-to-back reads from alternating owners allowed.
- Host worst-case wait without lock: STARVE_MAX cycles. With lock: STARVE_MAX plus the remaining burst length.
- Same-address write then read on consecutive cycles returns the new data.
- Simultaneous write and read to the same address cannot occur (single port).

## Structure
- Package iir_ram_pkg holds:
  - ADDR_W, DATA_W, BE_W constants.
  - owner_t enum {OWN_NONE, OWN_HOST, OWN_ENG}.
- Sub-module iir_ram_starve_ctr: saturating counter with clear/inc/max-flag, width $clog2(STARVE_MAX+1).
- The top holds the winner logic, RAM muxing, lock_held and rd_owner.

## Test plan
- Host only: write 0xDEADBEEF to addr 5 with be=0b0011, then read addr 5. Expect waitrequest 0 throughout, readdatavalid one cycle after the read, and readdata low 16 bits 0xBEEF.
- Engine only: back-to-back reads of addrs 0..4. Expect e_gnt=1 every cycle and e_rvalid for 5 consecutive cycles, each following its grant by 1 cycle.
- Contention, no lock, STARVE_MAX=8: engine requests continuously and the host holds a read. Expect the host granted on the 9th cycle, engine e_gnt=0 that cycle, and the engine resuming next cycle.
- Lock: starved host while the engine asserts e_lock for a 5-beat burst. Expect the host is not granted until the cycle after the last locked beat; starve_cnt stays saturated at 8.
- Alternating reads engine/host/engine. Expect each valid routed to the correct owner only, with no cross-assertion.
- Assert reset_n=0 the cycle after a granted host read. Expect no h_readdatavalid, h_waitrequest=1 during reset, and all state cleared; the first request after release is granted normally.
